// File: rtl/cosim_step_sequencer_if.sv
// Bundles retire-stage write reports, the step request/ack pair and the comparator beat stream.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface cosim_step_sequencer_if #(
  parameter int NumPorts = 2,
  parameter int KeyW     = 64,
  parameter int ValW     = 128,
  parameter int CntW     = 5
);
  logic [NumPorts-1:0]      wr_valid_i;
  logic [NumPorts*KeyW-1:0] wr_key_i;
  logic [NumPorts*ValW-1:0] wr_value_i;
  logic                     wr_ready_o;
  logic                     retire_valid_i;
  logic                     retire_ready_o;
  logic                     step_req_o;
  logic                     step_ack_i;
  logic                     cmp_valid_o;
  logic                     cmp_ready_i;
  logic [KeyW-1:0]          cmp_key_o;
  logic [ValW-1:0]          cmp_value_o;
  logic                     cmp_last_o;
  logic [CntW-1:0]          cmp_count_o;
  logic                     overflow_o;
  logic                     timeout_o;
  logic                     busy_o;

  modport slave (
    input  wr_valid_i, wr_key_i, wr_value_i, retire_valid_i, step_ack_i, cmp_ready_i,
    output wr_ready_o, retire_ready_o, step_req_o, cmp_valid_o, cmp_key_o, cmp_value_o,
           cmp_last_o, cmp_count_o, overflow_o, timeout_o, busy_o
  );

  modport master (
    output wr_valid_i, wr_key_i, wr_value_i, retire_valid_i, step_ack_i, cmp_ready_i,
    input  wr_ready_o, retire_ready_o, step_req_o, cmp_valid_o, cmp_key_o, cmp_value_o,
           cmp_last_o, cmp_count_o, overflow_o, timeout_o, busy_o
  );
endinterface

// File: rtl/cosim_step_sequencer.sv
// Batches register-write reports per retired instruction, requests one model step, then drains the batch in order.
// Retire->step_req 1 cycle, ack->first beat 1 cycle; reports stall during STEP/DRAIN, beats hold while cmp_ready_i=0.
module cosim_step_sequencer #(
  parameter int NumPorts         = 2,
  parameter int CommitLogEntries = 16,
  parameter int KeyW             = 64,
  parameter int ValW             = 128,
  parameter int TimeoutCycles    = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cosim_step_sequencer_if.slave  bus
);

  localparam int CntW  = $clog2(CommitLogEntries + 1);
  localparam int AddrW = (CommitLogEntries > 1) ? $clog2(CommitLogEntries) : 1;
  localparam int TmoW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] Depth   = CntW'(CommitLogEntries);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {COLLECT, STEP, DRAIN} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [KeyW-1:0]     r_key_mem [CommitLogEntries];
  logic [ValW-1:0]     r_val_mem [CommitLogEntries];
  logic [CntW-1:0]     r_count;
  logic [CntW-1:0]     r_rptr;
  logic [CntW-1:0]     r_cmp_count;
  logic [TmoW-1:0]     r_tmo;
  logic                r_overflow;
  logic                r_timeout;
  logic [CntW-1:0]     w_count_nxt;
  logic [NumPorts-1:0] w_wr_en;
  logic [AddrW-1:0]    w_wr_idx [NumPorts];
  logic                w_drop;
  logic                w_wr_ready;
  logic                w_retire_ready;
  logic                w_step_req;
  logic                w_cmp_valid;
  logic                w_retire_hs;
  logic                w_cmp_hs;
  logic                w_last;
  logic                w_tmo_hit;
  logic                w_have_item;

  assign w_tmo_hit   = (r_state == STEP) && (r_tmo == TmoLast);
  assign w_last      = (r_count == '0) || ((r_rptr + CntW'(1)) == r_count);
  assign w_have_item = (r_state == DRAIN) && (r_count != '0);
  assign w_retire_hs = w_retire_ready && bus.retire_valid_i;
  assign w_cmp_hs    = w_cmp_valid && bus.cmp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ready     = 1'b0;
    w_retire_ready = 1'b0;
    w_step_req     = 1'b0;
    w_cmp_valid    = 1'b0;
    unique case (r_state)
      COLLECT: begin
        w_wr_ready     = 1'b1;
        w_retire_ready = 1'b1;
        if (bus.retire_valid_i) w_state_nxt = STEP;
      end
      STEP: begin
        w_step_req = 1'b1;
        if (bus.step_ack_i || w_tmo_hit) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_cmp_valid = 1'b1;
        if (bus.cmp_ready_i && w_last) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Ports claim consecutive slots in ascending order; whatever does not fit is dropped.
  always_comb begin
    w_count_nxt = r_count;
    w_drop      = 1'b0;
    w_wr_en     = '0;
    for (int p = 0; p < NumPorts; p++) begin
      w_wr_idx[p] = '0;
      if (w_wr_ready && bus.wr_valid_i[p]) begin
        if (w_count_nxt < Depth) begin
          w_wr_en[p]  = 1'b1;
          w_wr_idx[p] = w_count_nxt[AddrW-1:0];
          w_count_nxt = w_count_nxt + CntW'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (w_wr_en[p]) begin
        r_key_mem[w_wr_idx[p]] <= bus.wr_key_i[p*KeyW +: KeyW];
        r_val_mem[w_wr_idx[p]] <= bus.wr_value_i[p*ValW +: ValW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count     <= '0;
      r_rptr      <= '0;
      r_cmp_count <= '0;
      r_tmo       <= '0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_drop) r_overflow <= 1'b1;
      if (w_retire_hs) r_cmp_count <= w_count_nxt;
      if ((r_state == STEP) && !bus.step_ack_i && !w_tmo_hit) begin
        r_tmo <= r_tmo + TmoW'(1);
      end else begin
        r_tmo <= '0;
      end
      if (w_tmo_hit && !bus.step_ack_i) r_timeout <= 1'b1;
      if (w_cmp_hs) begin
        if (w_last) begin
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          r_rptr <= r_rptr + CntW'(1);
        end
      end
    end
  end

  assign bus.wr_ready_o     = w_wr_ready;
  assign bus.retire_ready_o = w_retire_ready;
  assign bus.step_req_o     = w_step_req;
  assign bus.cmp_valid_o    = w_cmp_valid;
  assign bus.cmp_last_o     = w_cmp_valid && w_last;
  // An empty batch still yields one all-zero beat, so data is masked rather than read from stale slots.
  assign bus.cmp_key_o      = w_have_item ? r_key_mem[r_rptr[AddrW-1:0]] : '0;
  assign bus.cmp_value_o    = w_have_item ? r_val_mem[r_rptr[AddrW-1:0]] : '0;
  assign bus.cmp_count_o    = r_cmp_count;
  assign bus.overflow_o     = r_overflow;
  assign bus.timeout_o      = r_timeout;
  assign bus.busy_o         = (r_state != COLLECT);

endmodule

// File: tb/tb_cosim_step_sequencer.sv
// Bench for cosim_step_sequencer: a batch model fills an expected-beat queue on retire,
// and the drain task pops and compares each comparator handshake against it.
module tb_cosim_step_sequencer;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;

  logic [63:0]  exp_key [$];
  logic [127:0] exp_val [$];
  logic         exp_last [$];
  logic [4:0]   exp_cnt [$];
  logic [63:0]  mb_k [$];
  logic [127:0] mb_v [$];
  logic         m_ovf = 1'b0;

  always #5 clk_i = ~clk_i;

  cosim_step_sequencer_if #(.NumPorts(2), .KeyW(64), .ValW(128), .CntW(5)) bus ();

  cosim_step_sequencer #(
    .NumPorts(2), .CommitLogEntries(16), .KeyW(64), .ValW(128), .TimeoutCycles(8)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_cycle(input logic [1:0] vld, input logic [63:0] k0, input logic [127:0] v0,
                             input logic [63:0] k1, input logic [127:0] v1, input logic ret);
    int n;
    bus.wr_valid_i     = vld;
    bus.wr_key_i       = {k1, k0};
    bus.wr_value_i     = {v1, v0};
    bus.retire_valid_i = ret;
    checks++;
    if (bus.wr_ready_o !== 1'b1) begin
      errors++; $display("FAIL wr_ready_collect got %b exp 1", bus.wr_ready_o);
    end
    for (int p = 0; p < 2; p++) begin
      if (vld[p]) begin
        if (mb_k.size() < 16) begin
          mb_k.push_back(p == 0 ? k0 : k1);
          mb_v.push_back(p == 0 ? v0 : v1);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (ret) begin
      n = mb_k.size();
      if (n == 0) begin
        exp_key.push_back('0); exp_val.push_back('0); exp_last.push_back(1'b1); exp_cnt.push_back(5'd0);
      end else begin
        for (int i = 0; i < n; i++) begin
          exp_key.push_back(mb_k[i]); exp_val.push_back(mb_v[i]);
          exp_last.push_back(i == n - 1); exp_cnt.push_back(5'(n));
        end
      end
      mb_k.delete(); mb_v.delete();
    end
    tick();
    bus.wr_valid_i = '0; bus.wr_key_i = '0; bus.wr_value_i = '0; bus.retire_valid_i = 1'b0;
    checks++;
    if (bus.overflow_o !== m_ovf) begin
      errors++; $display("FAIL overflow got %b exp %b", bus.overflow_o, m_ovf);
    end
    if (ret) begin
      checks++;
      if (bus.step_req_o !== 1'b1) begin errors++; $display("FAIL step_req_after_retire got %b exp 1", bus.step_req_o); end
      checks++;
      if (bus.wr_ready_o !== 1'b0) begin errors++; $display("FAIL wr_ready_in_step got %b exp 0", bus.wr_ready_o); end
      checks++;
      if (bus.retire_ready_o !== 1'b0) begin errors++; $display("FAIL retire_ready_in_step got %b exp 0", bus.retire_ready_o); end
    end
  endtask

  task automatic do_ack();
    bus.step_ack_i = 1'b1;
    tick();
    bus.step_ack_i = 1'b0;
    checks++;
    if (bus.step_req_o !== 1'b0) begin errors++; $display("FAIL step_req_after_ack got %b exp 0", bus.step_req_o); end
    checks++;
    if (bus.cmp_valid_o !== 1'b1) begin errors++; $display("FAIL first_beat_latency got %b exp 1", bus.cmp_valid_o); end
  endtask

  task automatic drain(input bit toggle);
    int budget;
    bit rdy;
    budget = 200;
    rdy    = !toggle;
    while (exp_key.size() > 0 && budget > 0) begin
      bus.cmp_ready_i = rdy;
      checks++;
      if (bus.cmp_valid_o !== 1'b1) begin errors++; $display("FAIL drain_valid got %b exp 1", bus.cmp_valid_o); end
      checks++;
      if (bus.wr_ready_o !== 1'b0) begin errors++; $display("FAIL drain_wr_ready got %b exp 0", bus.wr_ready_o); end
      checks++;
      if (bus.cmp_key_o !== exp_key[0]) begin errors++; $display("FAIL beat_key got %h exp %h", bus.cmp_key_o, exp_key[0]); end
      checks++;
      if (bus.cmp_value_o !== exp_val[0]) begin errors++; $display("FAIL beat_value got %h exp %h", bus.cmp_value_o, exp_val[0]); end
      checks++;
      if (bus.cmp_last_o !== exp_last[0]) begin errors++; $display("FAIL beat_last got %b exp %b", bus.cmp_last_o, exp_last[0]); end
      checks++;
      if (bus.cmp_count_o !== exp_cnt[0]) begin errors++; $display("FAIL beat_count got %0d exp %0d", bus.cmp_count_o, exp_cnt[0]); end
      if (rdy) begin
        void'(exp_key.pop_front()); void'(exp_val.pop_front());
        void'(exp_last.pop_front()); void'(exp_cnt.pop_front());
      end
      tick();
      if (toggle) rdy = !rdy;
      budget--;
    end
    bus.cmp_ready_i = 1'b0;
    checks++;
    if (exp_key.size() != 0) begin errors++; $display("FAIL drain_budget left %0d exp 0", exp_key.size()); end
    checks++;
    if (bus.cmp_valid_o !== 1'b0) begin errors++; $display("FAIL valid_after_last got %b exp 0", bus.cmp_valid_o); end
    checks++;
    if (bus.wr_ready_o !== 1'b1) begin errors++; $display("FAIL wr_ready_after_last got %b exp 1", bus.wr_ready_o); end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    checks++;
    if ({bus.wr_ready_o, bus.retire_ready_o} !== 2'b11) begin
      errors++; $display("FAIL reset_readies got %b exp 11", {bus.wr_ready_o, bus.retire_ready_o});
    end
    checks++;
    if ({bus.step_req_o, bus.cmp_valid_o, bus.cmp_last_o, bus.overflow_o, bus.timeout_o, bus.busy_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000",
        {bus.step_req_o, bus.cmp_valid_o, bus.cmp_last_o, bus.overflow_o, bus.timeout_o, bus.busy_o});
    end
    checks++;
    if (bus.cmp_count_o !== 5'd0 || bus.cmp_key_o !== 64'd0) begin
      errors++; $display("FAIL reset_data got cnt %0d key %h exp 0", bus.cmp_count_o, bus.cmp_key_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_empty_batch();
    write_cycle(2'b00, '0, '0, '0, '0, 1'b1);
    do_ack();
    drain(1'b0);
  endtask

  task automatic test_two_ports();
    write_cycle(2'b11, 64'h50, 128'h1, 64'h61, 128'h2, 1'b0);
    write_cycle(2'b00, '0, '0, '0, '0, 1'b1);
    do_ack();
    drain(1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 7; i++) begin
      write_cycle(2'b11, 64'h100 + 64'(i), 128'(i), 64'h200 + 64'(i), 128'h1000 + 128'(i), 1'b0);
    end
    write_cycle(2'b01, 64'h1F0, 128'hF0, '0, '0, 1'b0);
    write_cycle(2'b11, 64'hAAA0, 128'hA0, 64'hBBB1, 128'hB1, 1'b1);
    do_ack();
    drain(1'b0);
    checks++;
    if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", bus.overflow_o); end
  endtask

  task automatic test_timeout();
    int n;
    bus.step_ack_i = 1'b1;
    tick();
    bus.step_ack_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.step_req_o !== 1'b0) begin
      errors++; $display("FAIL stray_ack got busy %b req %b exp 0 0", bus.busy_o, bus.step_req_o);
    end
    write_cycle(2'b01, 64'h3A1, 128'h77, '0, '0, 1'b0);
    write_cycle(2'b00, '0, '0, '0, '0, 1'b1);
    n = 0;
    while (bus.step_req_o === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL step_req_cycles got %0d exp 8", n); end
    checks++;
    if (bus.timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", bus.timeout_o); end
    drain(1'b0);
    checks++;
    if (bus.timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", bus.timeout_o); end
  endtask

  task automatic test_backpressure();
    write_cycle(2'b11, 64'h11, 128'hA1, 64'h22, 128'hA2, 1'b0);
    write_cycle(2'b01, 64'h33, 128'hA3, '0, '0, 1'b1);
    do_ack();
    drain(1'b1);
  endtask

  task automatic test_reset_mid_drain();
    write_cycle(2'b11, 64'h41, 128'hB1, 64'h42, 128'hB2, 1'b0);
    write_cycle(2'b01, 64'h43, 128'hB3, '0, '0, 1'b1);
    do_ack();
    bus.cmp_ready_i = 1'b1;
    checks++;
    if (bus.cmp_key_o !== exp_key[0]) begin errors++; $display("FAIL pre_reset_beat got %h exp %h", bus.cmp_key_o, exp_key[0]); end
    tick();
    bus.cmp_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({bus.cmp_valid_o, bus.cmp_last_o, bus.busy_o, bus.step_req_o, bus.overflow_o, bus.timeout_o} !== 6'b0) begin
      errors++; $display("FAIL async_reset_flags got %b exp 000000",
        {bus.cmp_valid_o, bus.cmp_last_o, bus.busy_o, bus.step_req_o, bus.overflow_o, bus.timeout_o});
    end
    checks++;
    if ({bus.wr_ready_o, bus.retire_ready_o} !== 2'b11) begin
      errors++; $display("FAIL async_reset_readies got %b exp 11", {bus.wr_ready_o, bus.retire_ready_o});
    end
    checks++;
    if (bus.cmp_count_o !== 5'd0 || bus.cmp_key_o !== 64'd0) begin
      errors++; $display("FAIL async_reset_data got cnt %0d key %h exp 0", bus.cmp_count_o, bus.cmp_key_o);
    end
    exp_key.delete(); exp_val.delete(); exp_last.delete(); exp_cnt.delete();
    mb_k.delete(); mb_v.delete();
    m_ovf = 1'b0;
    #2;
    rst_ni = 1'b1;
    bus.cmp_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.cmp_valid_o !== 1'b0) begin errors++; $display("FAIL beat_after_reset cycle %0d got %b exp 0", i, bus.cmp_valid_o); end
    end
    bus.cmp_ready_i = 1'b0;
    write_cycle(2'b00, '0, '0, '0, '0, 1'b1);
    do_ack();
    drain(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_ni             = 1'b0;
    bus.wr_valid_i     = '0;
    bus.wr_key_i       = '0;
    bus.wr_value_i     = '0;
    bus.retire_valid_i = 1'b0;
    bus.step_ack_i     = 1'b0;
    bus.cmp_ready_i    = 1'b0;
    test_reset();
    test_empty_batch();
    test_two_ports();
    test_overflow();
    test_timeout();
    test_backpressure();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cosim_step_sequencer.md
Name: cosim_step_sequencer

Overview:
- Sequences one co-simulation step per retired DUT instruction.
- Collects the DUT's register-write reports from several retire ports into a batch buffer.
- On instruction retire, requests one reference-model step, then drains the buffered batch in order to the commit-log comparator.
- Sits between the DUT retire stage, the DPI step driver and the comparator.

Parameters:
- NumPorts, 2, number of register-write report ports; port 0 has highest priority.
- CommitLogEntries, 16, batch buffer depth (items per instruction).
- KeyW, 64, register key width: {id, 4-bit type} packed, type in the low bits.
- ValW, 128, register value width.
- TimeoutCycles, 1024, maximum cycles to wait for step_ack_i.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- wr_valid_i  in  NumPorts  per-port register-write report valid.
- wr_key_i  in  NumPorts*KeyW  per-port key; port p occupies bits [p*KeyW +: KeyW].
- wr_value_i  in  NumPorts*ValW  per-port value.
- wr_ready_o  out  1  reports accepted this cycle (common to all ports).
- retire_valid_i  in  1  instruction retired; closes the current batch.
- retire_ready_o  out  1  retire accepted.
- step_req_o  out  1  level request to the DPI step driver.
- step_ack_i  in  1  single-cycle pulse: model step done.
- cmp_valid_o  out  1  comparator beat valid.
- cmp_ready_i  in  1  comparator accepts beat.
- cmp_key_o  out  KeyW  buffered key.
- cmp_value_o  out  ValW  buffered value.
- cmp_last_o  out  1  final beat of batch.
- cmp_count_o  out  $clog2(CommitLogEntries+1)  batch item count, constant over the batch.
- overflow_o  out  1  sticky: a report was dropped.
- timeout_o  out  1  sticky: step ack timed out.
- busy_o  out  1  FSM not in COLLECT.

Behaviour:
- Reset (async, rst_ni=0) clears everything immediately:
  - all outputs 0 except wr_ready_o=1 and retire_ready_o=1;
  - state=COLLECT, count=0, read pointer=0, timeout counter=0;
  - sticky flags cleared.
- A reset mid-batch discards the batch; no comparator beat is emitted afterwards.
- States: COLLECT, STEP, DRAIN.
- COLLECT:
  - wr_ready_o=1 and retire_ready_o=1.
  - Each cycle, every port with wr_valid_i=1 is written in ascending port order at index count, count+1, …
  - Ports beyond the free space are dropped and set overflow_o; count saturates at CommitLogEntries.
  - A retire handshake moves to STEP. Writes in the same cycle as the retire belong to the closing batch.
  - The batch count is latched into cmp_count_o at that transition.
- STEP:
  - step_req_o=1; wr_ready_o=0; retire_ready_o=0.
  - step_ack_i=1 -> DRAIN.
  - The timeout counter increments each STEP cycle. Reaching TimeoutCycles-1 without ack sets timeout_o and moves to DRAIN (batch still drained).
  - A step_ack_i received outside STEP is ignored.
- DRAIN:
  - cmp_valid_o=1; items are presented in insertion order from index 0.
  - Beat advances only on cmp_valid_o && cmp_ready_i.
  - cmp_last_o=1 on index count-1.
  - Empty batch (count=0): exactly one beat with key=0, value=0, cmp_count_o=0, cmp_last_o=1.
  - The last handshake returns to COLLECT, clears count and the read pointer, and sets cmp_valid_o=0 in the following cycle.
  - cmp outputs are held stable while cmp_ready_i=0.
- Latency, full batch with immediate ack and ready:
  - retire (cycle 0) -> step_req_o cycle 1;
  - ack cycle 1 -> first cmp beat cycle 2;
  - count beats back-to-back;
  - wr_ready_o high again the cycle after the last beat.
- Count arithmetic is unsigned; no wrap. The pointer never exceeds count-1.
- Sticky flags are cleared only by reset.

Test Plan:
- Retire with no writes, immediate ack, cmp_ready_i=1 -> step_req_o for 1 cycle; single beat with count=0, last=1, key/value=0; back to COLLECT.
- Port0 key=0x0000_0000_0000_0050 (x5) value=0x1, and port1 key=0x61 (f6) value=0x2 in the same cycle, then retire -> beats in order: 0x50/0x1 then 0x61/0x2; count=2; last on the 2nd beat.
- Write 15 items, then a cycle with both ports valid plus retire -> 16th item kept, port1 item dropped, overflow_o=1; 16 beats drained; overflow_o remains 1.
- step_ack_i never asserted with TimeoutCycles=8 -> step_req_o high 8 cycles; timeout_o=1; batch then drained normally.
- cmp_ready_i toggled 0/1 every cycle over a 3-item batch -> each beat held stable while ready=0; exactly 3 handshakes; wr_ready_o=0 throughout.
- rst_ni pulsed low during DRAIN after 1 of 3 beats -> outputs go to reset values immediately; no further beats; the next retire yields a count=0 batch.
